// File: rtl/rename_pkg.sv
// Shared widths, lane record and reset helpers for the rename stage.
// The RENAME_RECOVERY_EN build adds flush recovery (committed RAT plus commit head).
package rename_pkg;

    function automatic int aw_f(input int arch_regs);
        return (arch_regs > 1) ? $clog2(arch_regs) : 1;
    endfunction

    function automatic int pw_f(input int phys_regs);
        return (phys_regs > 1) ? $clog2(phys_regs) : 1;
    endfunction

    localparam int DEF_ARCH_REGS = 32;
    localparam int DEF_PHYS_REGS = 64;
    localparam int DEF_PAYLOAD_W = 64;
    localparam int DEF_PW        = pw_f(DEF_PHYS_REGS);

    // Lane record for the default configuration.
    typedef struct packed {
        logic [DEF_PW-1:0]        rd;
        logic [DEF_PW-1:0]        rd_old;
        logic [DEF_PW-1:0]        rs1;
        logic [DEF_PW-1:0]        rs2;
        logic [DEF_PAYLOAD_W-1:0] payload;
    } rename_lane_t;

    // At reset the ring holds every physical register above the architectural ones.
    // Slots past that range are never read before being written.
    function automatic int fl_reset_entry(input int slot, input int arch_regs, input int phys_regs);
        return (slot < phys_regs - arch_regs) ? arch_regs + slot : 0;
    endfunction

endpackage

// File: rtl/rename_free_list.sv
// Circular free list: multi-pop from head, in-order multi-push at tail.
// With RENAME_RECOVERY_EN it also keeps a commit head that restore rolls head back to.
module rename_free_list
    import rename_pkg::*;
#(
    parameter int WIDTH     = 2,
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64,
    localparam int PW       = pw_f(PHYS_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
`ifdef RENAME_RECOVERY_EN
    input  logic                     restore,
`endif
    input  logic [PW:0]              pop_cnt,
    input  logic [WIDTH-1:0]         push_valid,
    input  logic [WIDTH-1:0][PW-1:0] push_reg,
    output logic [WIDTH-1:0][PW-1:0] head_regs,
    output logic [PW:0]              free_count
);

    localparam logic [PW:0] RESET_TAIL = (PW+1)'(PHYS_REGS - ARCH_REGS);
    localparam logic [PW:0] CAPACITY   = (PW+1)'(PHYS_REGS - ARCH_REGS);

    logic [PW-1:0]           ring [PHYS_REGS];
    logic [PW:0]             head, tail, head_next, tail_next, push_cnt;
    logic [WIDTH-1:0][PW:0]  push_off;

    // Pushes are compacted: each valid lane lands after the valid lanes below it.
    always_comb begin
        push_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            push_off[i] = push_cnt;
            push_cnt    = push_cnt + (PW+1)'(push_valid[i]);
        end
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++)
            head_regs[i] = ring[head[PW-1:0] + PW'(i)];
    end

    assign free_count = tail - head;
    assign tail_next  = tail + push_cnt;

`ifdef RENAME_RECOVERY_EN
    logic [PW:0] chead, chead_next;

    // Every retire with a destination consumed exactly one entry, in order.
    assign chead_next = chead + push_cnt;
    assign head_next  = restore ? chead_next : head + pop_cnt;

    always_ff @(posedge clk) begin
        if (reset) chead <= '0;
        else       chead <= chead_next;
    end
`else
    assign head_next = head + pop_cnt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            head <= '0;
            tail <= RESET_TAIL;
        end else begin
            head <= head_next;
            tail <= tail_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < PHYS_REGS; s++)
                ring[s] <= PW'(fl_reset_entry(s, ARCH_REGS, PHYS_REGS));
        end else begin
            for (int i = 0; i < WIDTH; i++)
                if (push_valid[i])
                    ring[tail[PW-1:0] + push_off[i][PW-1:0]] <= push_reg[i];
        end
    end

    no_overfill: assert property (@(posedge clk) disable iff (reset)
        ((tail_next - head_next) <= CAPACITY));

endmodule

// File: rtl/rename_unit.sv
// N-wide register rename: RAT lookup, intra-bundle bypass, free-list allocation, output register.
// Define RENAME_RECOVERY_EN to add the flush port and committed-state recovery.
module rename_unit
    import rename_pkg::*;
#(
    parameter int WIDTH     = 2,
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64,
    parameter int PAYLOAD_W = 64,
    localparam int AW       = aw_f(ARCH_REGS),
    localparam int PW       = pw_f(PHYS_REGS)
) (
    input  logic                            clk,
    input  logic                            reset,
`ifdef RENAME_RECOVERY_EN
    input  logic                            flush,
`endif
    input  logic [WIDTH-1:0]                in_valid,
    output logic                            in_ready,
    input  logic [WIDTH-1:0][AW-1:0]        in_rd,
    input  logic [WIDTH-1:0][AW-1:0]        in_rs1,
    input  logic [WIDTH-1:0][AW-1:0]        in_rs2,
    input  logic [WIDTH-1:0]                in_has_rd,
    input  logic [WIDTH-1:0][PAYLOAD_W-1:0] in_payload,
    output logic [WIDTH-1:0]                out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0][PW-1:0]        out_rd,
    output logic [WIDTH-1:0][PW-1:0]        out_rd_old,
    output logic [WIDTH-1:0][PW-1:0]        out_rs1,
    output logic [WIDTH-1:0][PW-1:0]        out_rs2,
    output logic [WIDTH-1:0][PAYLOAD_W-1:0] out_payload,
    input  logic [WIDTH-1:0]                retire_valid,
    input  logic [WIDTH-1:0][AW-1:0]        retire_rd_arch,
    input  logic [WIDTH-1:0][PW-1:0]        retire_rd_phys,
    input  logic [WIDTH-1:0][PW-1:0]        retire_rd_old
);

    logic [PW-1:0]             rat [ARCH_REGS];
    logic [WIDTH-1:0]          alloc, ret_push;
    logic [PW:0]               need, free_count;
    logic [WIDTH-1:0][PW-1:0]  fl_head, new_rd, rd_old_m, rs1_m, rs2_m;
    logic                      flush_i, accept;

`ifdef RENAME_RECOVERY_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
    logic unused_retire_phys;
    assign unused_retire_phys = ^retire_rd_phys;
`endif

    always_comb begin
        for (int i = 0; i < WIDTH; i++)
            ret_push[i] = retire_valid[i] & (retire_rd_arch[i] != '0);
    end

    // Allocating lanes take consecutive free-list entries in lane order.
    always_comb begin : alloc_c
        int cnt;
        cnt = 0;
        for (int i = 0; i < WIDTH; i++) begin
            alloc[i]  = in_valid[i] & in_has_rd[i] & (in_rd[i] != '0);
            new_rd[i] = '0;
            for (int j = 0; j < WIDTH; j++)
                if (j == cnt) new_rd[i] = fl_head[j];
            if (alloc[i]) cnt = cnt + 1;
        end
        need = (PW+1)'(cnt);
    end

    // Lower lanes are scanned upward so the nearest older writer wins.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            rs1_m[i]    = (in_rs1[i] == '0) ? '0 : rat[in_rs1[i]];
            rs2_m[i]    = (in_rs2[i] == '0) ? '0 : rat[in_rs2[i]];
            rd_old_m[i] = rat[in_rd[i]];
            for (int j = 0; j < i; j++) begin
                if (alloc[j] && in_rd[j] == in_rs1[i]) rs1_m[i]    = new_rd[j];
                if (alloc[j] && in_rd[j] == in_rs2[i]) rs2_m[i]    = new_rd[j];
                if (alloc[j] && in_rd[j] == in_rd[i])  rd_old_m[i] = new_rd[j];
            end
            if (!alloc[i]) rd_old_m[i] = '0;
        end
    end

    assign in_ready = (out_ready | ~(|out_valid)) & (free_count >= need) & ~flush_i;
    assign accept   = in_ready & (|in_valid);

    rename_free_list #(
        .WIDTH     (WIDTH),
        .ARCH_REGS (ARCH_REGS),
        .PHYS_REGS (PHYS_REGS)
    ) u_free_list (
        .clk        (clk),
        .reset      (reset),
`ifdef RENAME_RECOVERY_EN
        .restore    (flush),
`endif
        .pop_cnt    (accept ? need : '0),
        .push_valid (ret_push),
        .push_reg   (retire_rd_old),
        .head_regs  (fl_head),
        .free_count (free_count)
    );

`ifdef RENAME_RECOVERY_EN
    logic [PW-1:0] crat [ARCH_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < ARCH_REGS; r++) crat[r] <= PW'(r);
        end else begin
            for (int i = 0; i < WIDTH; i++)
                if (ret_push[i]) crat[retire_rd_arch[i]] <= retire_rd_phys[i];
        end
    end
`endif

    // Later lanes overwrite earlier ones, so the youngest writer of an rd wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < ARCH_REGS; r++) rat[r] <= PW'(r);
        end
`ifdef RENAME_RECOVERY_EN
        else if (flush) begin
            for (int r = 0; r < ARCH_REGS; r++) rat[r] <= crat[r];
            for (int i = 0; i < WIDTH; i++)
                if (ret_push[i]) rat[retire_rd_arch[i]] <= retire_rd_phys[i];
        end
`endif
        else if (accept) begin
            for (int i = 0; i < WIDTH; i++)
                if (alloc[i]) rat[in_rd[i]] <= new_rd[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= '0;
            out_rd      <= '0;
            out_rd_old  <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_payload <= '0;
        end else if (flush_i) begin
            out_valid <= '0;
        end else if (accept) begin
            out_valid <= in_valid;
            for (int i = 0; i < WIDTH; i++)
                out_rd[i] <= alloc[i] ? new_rd[i] : '0;
            out_rd_old  <= rd_old_m;
            out_rs1     <= rs1_m;
            out_rs2     <= rs2_m;
            out_payload <= in_payload;
        end else if (out_ready) begin
            out_valid <= '0;
        end
    end

endmodule

// File: tb/tb_rename_unit.sv
// Bench for rename_unit (WIDTH=2, 32 arch, 64 phys): vector table plus scoreboard on the output.
module tb_rename_unit;
    import rename_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    logic [1:0]        in_valid, in_has_rd, out_valid, retire_valid;
    logic              in_ready, out_ready;
    logic [1:0][4:0]   in_rd, in_rs1, in_rs2, retire_rd_arch;
    logic [1:0][63:0]  in_payload, out_payload;
    logic [1:0][5:0]   out_rd, out_rd_old, out_rs1, out_rs2, retire_rd_phys, retire_rd_old;

    always #5 clk = ~clk;

    rename_unit #(.WIDTH(2), .ARCH_REGS(32), .PHYS_REGS(64), .PAYLOAD_W(64)) dut (
        .clk(clk), .reset(reset),
`ifdef RENAME_RECOVERY_EN
        .flush(flush),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_has_rd(in_has_rd), .in_payload(in_payload),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_rd_old(out_rd_old), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_payload(out_payload), .retire_valid(retire_valid),
        .retire_rd_arch(retire_rd_arch), .retire_rd_phys(retire_rd_phys),
        .retire_rd_old(retire_rd_old)
    );

    typedef struct {
        logic [1:0] v, has;
        logic [4:0] rd [2];
        logic [4:0] rs1 [2];
        logic [4:0] rs2 [2];
        bit         ready;
        logic [5:0] erd [2];
        logic [5:0] eold [2];
        logic [5:0] ers1 [2];
        logic [5:0] ers2 [2];
    } vec_t;

    typedef struct {
        logic [1:0]   mask;
        rename_lane_t lane [2];
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   tag_ctr = 0;
    exp_t sb [$];
    exp_t mon_e;
    vec_t vt [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] v, input logic [1:0] has,
                                input int r0, input int a0, input int b0,
                                input int r1, input int a1, input int b1, input bit rdy,
                                input int er0, input int eo0, input int ea0, input int eb0,
                                input int er1, input int eo1, input int ea1, input int eb1);
        vec_t t;
        t.v = v; t.has = has; t.ready = rdy;
        t.rd[0] = 5'(r0); t.rs1[0] = 5'(a0); t.rs2[0] = 5'(b0);
        t.rd[1] = 5'(r1); t.rs1[1] = 5'(a1); t.rs2[1] = 5'(b1);
        t.erd[0] = 6'(er0); t.eold[0] = 6'(eo0); t.ers1[0] = 6'(ea0); t.ers2[0] = 6'(eb0);
        t.erd[1] = 6'(er1); t.eold[1] = 6'(eo1); t.ers1[1] = 6'(ea1); t.ers2[1] = 6'(eb1);
        return t;
    endfunction

    function automatic int a_of(input int k); return 1 + (7 * k) % 62; endfunction
    function automatic int b_of(input int k); return 1 + (11 * k + 3) % 62; endfunction

    // Called just after a rising edge; returns just after the next one.
    task automatic apply(input vec_t v);
        exp_t e;
        tag_ctr++;
        in_valid  = v.v;
        in_has_rd = v.has;
        for (int l = 0; l < 2; l++) begin
            in_rd[l]      = v.rd[l];
            in_rs1[l]     = v.rs1[l];
            in_rs2[l]     = v.rs2[l];
            in_payload[l] = {32'(tag_ctr), 32'hbeef0000 + 32'(l)};
        end
        @(negedge clk);
        chk($sformatf("in_ready bundle %0d", tag_ctr), 64'(in_ready), 64'(v.ready));
        if (v.ready) begin
            e.mask = v.v;
            for (int l = 0; l < 2; l++) begin
                e.lane[l].rd      = v.erd[l];
                e.lane[l].rd_old  = v.eold[l];
                e.lane[l].rs1     = v.ers1[l];
                e.lane[l].rs2     = v.ers2[l];
                e.lane[l].payload = {32'(tag_ctr), 32'hbeef0000 + 32'(l)};
            end
            sb.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = '0;
    endtask

    task automatic check_reset_state();
        @(negedge clk);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_rd", 64'(out_rd), 64'd0);
        chk("reset out_rd_old", 64'(out_rd_old), 64'd0);
        chk("reset out_rs", 64'({out_rs1, out_rs2}), 64'd0);
        chk("reset out_payload", out_payload[0] | out_payload[1], 64'd0);
        chk("reset in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (!reset && out_ready && out_valid != 2'b00) begin
            if (sb.size() == 0) begin
                chk("unexpected out_valid", 64'(out_valid), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("out_valid", 64'(out_valid), 64'(mon_e.mask));
                for (int l = 0; l < 2; l++) begin
                    if (mon_e.mask[l]) begin
                        chk($sformatf("lane%0d rd", l), 64'(out_rd[l]), 64'(mon_e.lane[l].rd));
                        chk($sformatf("lane%0d rd_old", l), 64'(out_rd_old[l]), 64'(mon_e.lane[l].rd_old));
                        chk($sformatf("lane%0d rs1", l), 64'(out_rs1[l]), 64'(mon_e.lane[l].rs1));
                        chk($sformatf("lane%0d rs2", l), 64'(out_rs2[l]), 64'(mon_e.lane[l].rs2));
                        chk($sformatf("lane%0d payload", l), out_payload[l], mon_e.lane[l].payload);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, p1;
        vt[0] = mk(2'b11, 2'b11, 1, 2, 3,  4, 1, 1, 1, 32, 1, 2, 3,    33, 4, 32, 32);
        vt[1] = mk(2'b11, 2'b11, 5, 1, 4,  5, 5, 0, 1, 34, 5, 32, 33,  35, 34, 34, 0);
        vt[2] = mk(2'b11, 2'b10, 7, 5, 1,  0, 4, 5, 1, 0, 0, 35, 32,   0, 0, 33, 35);
        vt[3] = mk(2'b10, 2'b11, 9, 0, 0,  6, 6, 0, 1, 0, 0, 0, 0,     36, 6, 6, 0);
        vt[4] = mk(2'b11, 2'b11, 7, 1, 6,  8, 7, 5, 1, 37, 7, 32, 36,  38, 8, 37, 35);

        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        in_valid = '0; in_has_rd = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_payload = '0;
        retire_valid = '0; retire_rd_arch = '0; retire_rd_phys = '0; retire_rd_old = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_reset_state();

        for (int i = 0; i < 5; i++) apply(vt[i]);

        // Drain the free list down to a single entry.
        for (int k = 0; k < 12; k++)
            apply(mk(2'b11, 2'b11, 10, 0, 0, 11, 0, 0, 1,
                     39 + 2*k, (k == 0) ? 10 : 37 + 2*k, 0, 0,
                     40 + 2*k, (k == 0) ? 11 : 38 + 2*k, 0, 0));

        // One free, two needed: stall even though retire frees one this cycle.
        retire_valid = 2'b11;
        retire_rd_arch[0] = 5'd0; retire_rd_old[0] = 6'd55; retire_rd_phys[0] = 6'd3;
        retire_rd_arch[1] = 5'd9; retire_rd_old[1] = 6'd9;  retire_rd_phys[1] = 6'd4;
        apply(mk(2'b11, 2'b11, 7, 0, 0, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        retire_valid = '0;
        apply(mk(2'b11, 2'b11, 7, 0, 0, 8, 0, 0, 1, 63, 37, 0, 0, 9, 38, 0, 0));
        apply(mk(2'b01, 2'b00, 0, 7, 8, 0, 0, 0, 1, 0, 0, 63, 9, 0, 0, 0, 0));

        retire_valid = 2'b01; retire_rd_arch[0] = 5'd10; retire_rd_old[0] = 6'd10;
        @(posedge clk); #1;
        retire_valid = '0;
        apply(mk(2'b01, 2'b01, 12, 10, 11, 0, 0, 0, 1, 10, 12, 61, 62, 0, 0, 0, 0));

        // Pointers run past 64 while retiring and allocating back to back.
        retire_valid = 2'b11; retire_rd_arch[0] = 5'd20; retire_rd_arch[1] = 5'd20;
        retire_rd_old[0] = 6'(a_of(0)); retire_rd_old[1] = 6'(b_of(0));
        @(posedge clk); #1;
        p0 = 14; p1 = 15;
        for (int k = 1; k <= 20; k++) begin
            if (k < 20) begin
                retire_rd_old[0] = 6'(a_of(k)); retire_rd_old[1] = 6'(b_of(k));
            end else begin
                retire_valid = '0;
            end
            apply(mk(2'b11, 2'b11, 14, 14, 0, 15, 14, 15, 1,
                     a_of(k-1), p0, p0, 0, b_of(k-1), p1, a_of(k-1), p1));
            p0 = a_of(k-1); p1 = b_of(k-1);
        end

        // Backpressure: output holds, nothing advances.
        retire_valid = 2'b11; retire_rd_old[0] = 6'd40; retire_rd_old[1] = 6'd41;
        @(posedge clk); #1;
        retire_valid = '0;
        apply(mk(2'b01, 2'b01, 16, 14, 15, 0, 0, 0, 1, 40, 16, p0, p1, 0, 0, 0, 0));
        out_ready = 1'b0;
        for (int h = 0; h < 3; h++) begin
            apply(mk(2'b01, 2'b01, 16, 16, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            chk("hold out_valid", 64'(out_valid), 64'd1);
            chk("hold out_rd", 64'(out_rd[0]), 64'd40);
            chk("hold out_rd_old", 64'(out_rd_old[0]), 64'd16);
        end
        out_ready = 1'b1;
        apply(mk(2'b01, 2'b01, 16, 16, 0, 0, 0, 0, 1, 41, 40, 40, 0, 0, 0, 0, 0));
        apply(mk(2'b01, 2'b00, 0, 16, 0, 0, 0, 0, 1, 0, 0, 41, 0, 0, 0, 0, 0));

        // Reset with a bundle still in the output register.
        reset = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_reset_state();
        apply(vt[0]);

`ifdef RENAME_RECOVERY_EN
        flush = 1'b1;
        @(negedge clk);
        chk("flush in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush out_valid", 64'(out_valid), 64'd0);
        apply(vt[0]);
`endif

        repeat (3) @(posedge clk);
        chk("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
